// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: ALU op codes and FSM state encoding.
package alu_seq_pkg;

  localparam logic [2:0] OP_ZERO = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_NOTA = 3'b110;
  localparam logic [2:0] OP_ONES = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_flags.sv
// Combinational zero/carry flags derived from the registered ALU operands and the ALU result.
// Instantiated by alu_cmd_sequencer only when ALU_SEQ_FLAGS_EN is defined.
module alu_seq_flags
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] alu_a_i,
  input  logic [WIDTH-1:0] alu_b_i,
  input  logic [2:0]       alu_sel_i,
  input  logic [WIDTH-1:0] alu_y_i,
  output logic             zero_o,
  output logic             carry_o
);

  logic [WIDTH:0] sum_s;

  assign sum_s  = {1'b0, alu_a_i} + {1'b0, alu_b_i};
  assign zero_o = (alu_y_i == {WIDTH{1'b0}});

  // Carry is the adder carry-out for ADD and the borrow for SUB; other ops never carry.
  always_comb begin
    carry_o = 1'b0;
    case (alu_sel_i)
      OP_ADD:  carry_o = sum_s[WIDTH];
      OP_SUB:  carry_o = (alu_a_i < alu_b_i);
      default: carry_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Valid/ready command initiator for the external 8-bit ALU with an internal accumulator.
// Optional flag outputs (rsp_zero, rsp_carry) are built only when ALU_SEQ_FLAGS_EN is defined.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_use_acc,
  input  logic             cmd_wr_acc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic [WIDTH-1:0] acc
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic             rsp_zero,
  output logic             rsp_carry
`endif
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_sel_q, alu_sel_d;
  logic             wr_acc_q, wr_acc_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
`ifdef ALU_SEQ_FLAGS_EN
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             zero_s, carry_s;

  alu_seq_flags #(.WIDTH(WIDTH)) u_flags (
    .alu_a_i   (alu_a_q),
    .alu_b_i   (alu_b_q),
    .alu_sel_i (alu_sel_q),
    .alu_y_i   (alu_y),
    .zero_o    (zero_s),
    .carry_o   (carry_s)
  );
`endif

  // Next-state and datapath capture; operands stay frozen from acceptance until the handshake.
  always_comb begin
    state_d   = state_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sel_d = alu_sel_q;
    wr_acc_d  = wr_acc_q;
    acc_d     = acc_q;
    rsp_y_d   = rsp_y_q;
`ifdef ALU_SEQ_FLAGS_EN
    zero_d    = zero_q;
    carry_d   = carry_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          alu_a_d   = cmd_use_acc ? acc_q : cmd_a;
          alu_b_d   = cmd_b;
          alu_sel_d = cmd_op;
          wr_acc_d  = cmd_wr_acc;
          state_d   = S_ISSUE;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_ISSUE: begin
        rsp_y_d = alu_y;
        if (wr_acc_q) begin
          acc_d = alu_y;
        end else begin
          acc_d = acc_q;
        end
`ifdef ALU_SEQ_FLAGS_EN
        zero_d  = zero_s;
        carry_d = carry_s;
`endif
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      alu_a_q   <= {WIDTH{1'b0}};
      alu_b_q   <= {WIDTH{1'b0}};
      alu_sel_q <= 3'b000;
      wr_acc_q  <= 1'b0;
      acc_q     <= {WIDTH{1'b0}};
      rsp_y_q   <= {WIDTH{1'b0}};
`ifdef ALU_SEQ_FLAGS_EN
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      wr_acc_q  <= wr_acc_d;
      acc_q     <= acc_d;
      rsp_y_q   <= rsp_y_d;
`ifdef ALU_SEQ_FLAGS_EN
      zero_q    <= zero_d;
      carry_q   <= carry_d;
`endif
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_y     = rsp_y_q;
  assign acc       = acc_q;
`ifdef ALU_SEQ_FLAGS_EN
  assign rsp_zero  = zero_q;
  assign rsp_carry = carry_q;
`endif

endmodule
